// File: rtl/debug_hex_scanner_if.sv
// debug_hex_scanner_if: groups the debug bus inputs and the seven-segment
// drive outputs of debug_hex_scanner into one bundle.
// master = the side that drives the debug bus and watches the display,
// slave  = the scanner itself.
interface debug_hex_scanner_if;
  logic [63:0] debug_reg;
  logic [1:0]  page;
  logic        freeze;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        tick;

  modport master (
    output debug_reg, page, freeze,
    input  seg, dp, an, tick
  );

  modport slave (
    input  debug_reg, page, freeze,
    output seg, dp, an, tick
  );
endinterface

// File: rtl/debug_hex_scanner.sv
// debug_hex_scanner: shows one 16-bit page of the 64-bit processor debug bus
// on a 4-digit multiplexed seven-segment display (all drives active-low).
// A free-running DIV_W-bit prescaler produces a registered wrap pulse (tick);
// each tick advances the digit index and re-registers an/seg/dp, so the
// display outputs only ever change on a tick edge.
// Optional feature macro: DEBUG_SCAN_BLANK_EN enables leading-zero blanking
// of digits 3..1 (digit 0 is always shown).
module debug_hex_scanner #(
  parameter int DIV_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  debug_hex_scanner_if.slave  bus
);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      snap_q, snap_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       nibble_s;
  logic             blank_s;

  // Hex nibble to active-low segment pattern, ordered {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      4'hF:    pat = 7'b0001110;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Next-state logic: prescaler, snapshot, and per-tick digit output update.
  always_comb begin
    div_d    = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
    tick_d   = &div_q;
    idx_d    = idx_q;
    an_d     = an_q;
    seg_d    = seg_q;
    dp_d     = dp_q;
    nibble_s = 4'h0;
    blank_s  = 1'b0;

    if (bus.freeze) begin
      snap_d = snap_q;
    end else begin
      snap_d = bus.debug_reg[{bus.page, 4'b0000} +: 16];
    end

    if (tick_q) begin
      // Outputs are registered for the new index, using snap as of this edge.
      idx_d    = idx_q + 2'd1;
      nibble_s = snap_q[{idx_d, 2'b00} +: 4];
`ifdef DEBUG_SCAN_BLANK_EN
      case (idx_d)
        2'd3:    blank_s = (snap_q[15:12] == 4'h0);
        2'd2:    blank_s = (snap_q[15:8]  == 8'h00);
        2'd1:    blank_s = (snap_q[15:4]  == 12'h000);
        default: blank_s = 1'b0;
      endcase
`else
      blank_s = 1'b0;
`endif
      dp_d = ~(bus.freeze && (idx_d == 2'd0));
      if (blank_s) begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
      end else begin
        an_d  = ~(4'b0001 << idx_d);
        seg_d = hex_decode(nibble_s);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // State registers; idx resets to 3 so the first tick lands on digit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      idx_q  <= 2'd3;
      snap_q <= 16'h0000;
      an_q   <= 4'b1111;
      seg_q  <= 7'b1111111;
      dp_q   <= 1'b1;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = dp_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_debug_hex_scanner.sv
// tb_debug_hex_scanner: directed, table-driven bench for debug_hex_scanner
// with DIV_W = 2 (one tick every 4 clocks). Expected values are hand-decoded.
module tb_debug_hex_scanner;

  localparam int DIV_W = 2;
`ifdef DEBUG_SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam logic [63:0] D  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] X  = 64'h0000_0000_8A1B_0000;
  localparam logic [63:0] Z  = 64'h0;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  debug_hex_scanner_if bus ();

  debug_hex_scanner #(.DIV_W(DIV_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] dbg;
    logic [1:0]  page;
    logic        frz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Runs up to and including one tick edge; n_pre is the number of edges
  // before tick is seen high (4 right after reset, 3 afterwards).
  task automatic run_digit(input int n_pre, input logic [3:0] ean,
                           input logic [6:0] eseg, input logic edp, input string tag);
    logic [3:0] an0;
    logic [6:0] seg0;
    an0  = bus.an;
    seg0 = bus.seg;
    for (int k = 0; k < n_pre - 1; k++) begin
      @(posedge clk); @(negedge clk);
      chk({tag, " tick_low"}, {31'd0, bus.tick}, 32'd0);
      chk({tag, " an_stable"}, {28'd0, bus.an}, {28'd0, an0});
      chk({tag, " seg_stable"}, {25'd0, bus.seg}, {25'd0, seg0});
    end
    @(posedge clk); @(negedge clk);
    chk({tag, " tick_high"}, {31'd0, bus.tick}, 32'd1);
    chk({tag, " an_hold"}, {28'd0, bus.an}, {28'd0, an0});
    @(posedge clk); @(negedge clk);
    chk({tag, " tick_clear"}, {31'd0, bus.tick}, 32'd0);
    chk({tag, " an"}, {28'd0, bus.an}, {28'd0, ean});
    chk({tag, " seg"}, {25'd0, bus.seg}, {25'd0, eseg});
    chk({tag, " dp"}, {31'd0, bus.dp}, {31'd0, edp});
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // page 0 of D: CDEF scanned F, E, d, C
    vecs[0]  = '{D, 2'd0, 1'b0, 4'b1110, 7'b0001110, 1'b1};
    vecs[1]  = '{D, 2'd0, 1'b0, 4'b1101, 7'b0000110, 1'b1};
    vecs[2]  = '{D, 2'd0, 1'b0, 4'b1011, 7'b0100001, 1'b1};
    vecs[3]  = '{D, 2'd0, 1'b0, 4'b0111, 7'b1000110, 1'b1};
    // page 3 of D: 0123, digit 3 is a leading zero
    vecs[4]  = '{D, 2'd3, 1'b0, 4'b1110, 7'b0110000, 1'b1};
    vecs[5]  = '{D, 2'd3, 1'b0, 4'b1101, 7'b0100100, 1'b1};
    vecs[6]  = '{D, 2'd3, 1'b0, 4'b1011, 7'b1111001, 1'b1};
    vecs[7]  = '{D, 2'd3, 1'b0, BLANK ? 4'b1111 : 4'b0111,
                 BLANK ? 7'b1111111 : 7'b1000000, 1'b1};
    // reload CDEF, then freeze and zero the bus
    vecs[8]  = '{D, 2'd0, 1'b0, 4'b1110, 7'b0001110, 1'b1};
    vecs[9]  = '{Z, 2'd0, 1'b1, 4'b1101, 7'b0000110, 1'b1};
    vecs[10] = '{Z, 2'd0, 1'b1, 4'b1011, 7'b0100001, 1'b1};
    vecs[11] = '{Z, 2'd0, 1'b1, 4'b0111, 7'b1000110, 1'b1};
    vecs[12] = '{Z, 2'd0, 1'b1, 4'b1110, 7'b0001110, 1'b0};
    vecs[13] = '{Z, 2'd3, 1'b1, 4'b1101, 7'b0000110, 1'b1};
    // unfreeze: zeros appear
    vecs[14] = '{Z, 2'd0, 1'b0, BLANK ? 4'b1111 : 4'b1011,
                 BLANK ? 7'b1111111 : 7'b1000000, 1'b1};
    vecs[15] = '{Z, 2'd0, 1'b0, BLANK ? 4'b1111 : 4'b0111,
                 BLANK ? 7'b1111111 : 7'b1000000, 1'b1};
    vecs[16] = '{Z, 2'd0, 1'b0, 4'b1110, 7'b1000000, 1'b1};
    vecs[17] = '{Z, 2'd0, 1'b0, BLANK ? 4'b1111 : 4'b1101,
                 BLANK ? 7'b1111111 : 7'b1000000, 1'b1};
    // page 1 = 8A1B: A, 8, then wrap to b, 1
    vecs[18] = '{X, 2'd1, 1'b0, 4'b1011, 7'b0001000, 1'b1};
    vecs[19] = '{X, 2'd1, 1'b0, 4'b0111, 7'b0000000, 1'b1};
    vecs[20] = '{X, 2'd1, 1'b0, 4'b1110, 7'b0000011, 1'b1};
    vecs[21] = '{X, 2'd1, 1'b0, 4'b1101, 7'b1111001, 1'b1};

    reset         = 1'b1;
    bus.debug_reg = D;
    bus.page      = 2'd0;
    bus.freeze    = 1'b0;
    #12;
    chk("reset an", {28'd0, bus.an}, 32'hF);
    chk("reset seg", {25'd0, bus.seg}, 32'h7F);
    chk("reset dp", {31'd0, bus.dp}, 32'd1);
    chk("reset tick", {31'd0, bus.tick}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      bus.debug_reg = vecs[i].dbg;
      bus.page      = vecs[i].page;
      bus.freeze    = vecs[i].frz;
      run_digit((i == 0) ? 4 : 3, vecs[i].an, vecs[i].seg, vecs[i].dp,
                $sformatf("vec%0d", i));
    end

    // Async reset while tick is high, between clock edges.
    bus.debug_reg = D;
    bus.page      = 2'd0;
    bus.freeze    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_reset tick", {31'd0, bus.tick}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async an", {28'd0, bus.an}, 32'hF);
    chk("async seg", {25'd0, bus.seg}, 32'h7F);
    chk("async dp", {31'd0, bus.dp}, 32'd1);
    chk("async tick", {31'd0, bus.tick}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_digit(4, 4'b1110, 7'b0001110, 1'b1, "rst_first");
    run_digit(3, 4'b1101, 7'b0000110, 1'b1, "rst_second");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_hex_scanner.md
# debug_hex_scanner

- Drives the board's 4-digit multiplexed seven-segment display from the processor's 64-bit debug register bus.
- Sits directly downstream of the processor's `debug_reg` output in the top level.
- Selects one 16-bit page of the bus and snapshots it, with an optional freeze.
- Time-multiplexes the four hex digits using a free-running prescaler on the board clock.

## Interface

Parameters:
- `DIV_W`, default 16: prescaler width; each digit is active for 2^DIV_W clk cycles.

Ports:
- `clk` input 1: board clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `debug_reg` input 64: processor debug bus.
- `page` input 2: selects the slice `debug_reg[16*page +: 16]`.
- `freeze` input 1: level; while high, the snapshot holds its value.
- `seg` output 7: segment drive, active-low, ordered {g,f,e,d,c,b,a}.
- `dp` output 1: decimal point, active-low.
- `an` output 4: digit enables, active-low, one-hot; `an[i]` enables digit i, digit 0 is rightmost.
- `tick` output 1: one-cycle pulse on every digit advance.

## Operation

Snapshot:
- `snap[15:0]` loads the selected slice on every clk edge while `freeze` = 0.
- `snap` holds while `freeze` = 1.

Prescaler:
- `div` is a DIV_W-bit counter that increments every cycle and wraps from all-ones to 0.
- The registered wrap pulse is `tick`.

Digit index:
- `idx` is 2 bits and increments on `tick`, wrapping 3 -> 0.
- On the `tick` edge, the outputs are registered for the new `idx`:
  - `an` = ~(1 << idx)
  - `seg` = hexdecode(`snap[4*idx +: 4]`)
  - `dp` = ~(`freeze` && idx == 0)

Hex decode (active-low, {g..a}):
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
- 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
- 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
- C = 1000110, d = 0100001, E = 0000110, F = 0001110

Between ticks, `an`, `seg` and `dp` are stable; no glitches are allowed.

Reset values:
- `div` = 0, `idx` = 3 (so that the first tick selects digit 0), `snap` = 0.
- `an` = 1111, `seg` = 1111111, `dp` = 1, `tick` = 0.
- The display stays blank until the first tick.

## Timing

- `snap` reflects `page` and `debug_reg` with 1 cycle of latency.
- The first `tick` goes high in cycle 2^DIV_W after reset release (cycle 0 is the first edge after release). This first tick selects digit 0.
- Subsequent ticks come every 2^DIV_W cycles; a full refresh takes 4·2^DIV_W cycles.
- Digit outputs use the `snap` value present at the tick edge. A `snap` change mid-digit appears at the next tick.
- If `freeze` rises in cycle n, `snap` keeps the value loaded at edge n-1.
- `dp` on digit 0 follows `freeze` at tick edges only.
- A `page` change during freeze has no effect until `freeze` falls; the new slice is then loaded 1 cycle later.
- Reset asserted mid-scan clears everything immediately (asynchronously). Scanning restarts from the reset timing above.

## Configuration

Macro `DEBUG_SCAN_BLANK_EN` (leading-zero blanking):
- Defined: digit i (i = 3, 2, 1) is blanked when `snap[15:4*i]` == 0. Blanking means `an` all 1s and `seg` = 1111111 for that digit slot. `tick` and `idx` are unaffected. Digit 0 is never blanked, so `snap` = 0 shows a single "0".
- Undefined: all four digits are always shown, including leading zeros.

## Test plan

All scenarios run with DIV_W = 2, so a tick occurs every 4 cycles.

- Reset, then hold `debug_reg` = 64'h0123_4567_89AB_CDEF, `page` = 0:
  - ticks at cycles 4, 8, 12, 16 give `an` = 1110, 1101, 1011, 0111;
  - `seg` = F, E, d, C, i.e. 0001110, 0000110, 0100001, 1000110.
- `page` = 3 with the same bus → digit 0 shows 3 = 0110000 and digit 3 shows 0 = 1000000. Under `DEBUG_SCAN_BLANK_EN`, digit 3 is blanked instead: `an` = 1111 in that slot.
- `freeze` = 1 with `snap` = 16'hCDEF, then change `debug_reg` to all-zero:
  - the display still cycles F, E, d, C;
  - `dp` = 0 only while digit 0 is enabled;
  - after `freeze` = 0, zeros appear from the next ticks.
- Assert `reset` asynchronously between edges mid-scan → `an` = 1111, `seg` = 1111111, `tick` = 0 without waiting for a clk edge. After release, the first tick is again at cycle 4 and shows digit 0.
- `debug_reg` slice = 16'h0000 with `DEBUG_SCAN_BLANK_EN` defined:
  - only digit 0 is lit, showing 1000000;
  - the other three slots show `an` = 1111;
  - `tick` keeps pulsing every 4 cycles.
- `debug_reg` slice = 16'h8A1b → digits show b, 1, A, 8 = 0000011, 1111001, 0001000, 0000000. The `idx` wrap 3 → 0 reselects `an` = 1110.
